// File: rtl/alu_branch_sequencer.sv
// alu_branch_sequencer: fixed four-cycle fetch/decode/execute/writeback sequencer that
// drives a combinational 4-bit ALU from a 16-bit instruction ROM and a 4-entry regfile.
module alu_branch_sequencer #(
    parameter int unsigned PC_W   = 6,
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [PC_W-1:0]   instr_addr,
    output logic              instr_rd,
    input  logic [15:0]       instr_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              busy,
    output logic              halted,
    output logic [PC_W-1:0]   pc,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned NREGS      = 4;
    localparam logic [2:0]  OP_SPECIAL = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALTED
    } state_t;

    state_t              state, state_n;
    logic [INSTR_W-1:0]  ir, ir_n;
    logic [PC_W-1:0]     pc_n;
    logic [DATA_W-1:0]   regs [NREGS];
    logic [DATA_W-1:0]   res_q;
    logic                zero_q;

    logic                instr_rd_n, busy_n, halted_n;
    logic [DATA_W-1:0]   alu_a_n, alu_b_n;
    logic [2:0]          alu_op_n;

    // Class of the latched instruction, used during writeback
    logic                ir_br;
    logic [2:0]          ir_op;
    logic [1:0]          ir_rd;
    logic                is_halt, is_ldi, is_alu, is_branch;
    logic                wr_en;
    logic [DATA_W-1:0]   wr_data;

    assign ir_br     = ir[15];
    assign ir_op     = ir[14:12];
    assign ir_rd     = ir[11:10];
    assign is_halt   = !ir_br && (ir_op == OP_SPECIAL);
    assign is_ldi    =  ir_br && (ir_op == OP_SPECIAL);
    assign is_alu    = !ir_br && (ir_op != OP_SPECIAL);
    assign is_branch =  ir_br && (ir_op != OP_SPECIAL);

    assign wr_en      = (state == S_WB) && (is_alu || is_ldi);
    assign wr_data    = is_ldi ? ir[DATA_W-1:0] : res_q;
    assign instr_addr = pc;
    assign dbg_data   = regs[dbg_sel];

    // State, pc, instruction and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= '0;
            ir       <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            instr_rd <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ir       <= ir_n;
            instr_rd <= instr_rd_n;
            busy     <= busy_n;
            halted   <= halted_n;
            alu_a    <= alu_a_n;
            alu_b    <= alu_b_n;
            alu_op   <= alu_op_n;
            if (state == S_EXEC) begin
                res_q  <= alu_result;
                zero_q <= alu_zero;
            end
        end
    end

    // Register file: only written in WB, cleared by reset (abandons any in-flight write)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[ir_rd] <= wr_data;
        end
    end

    // Next state, pc and next-cycle output values
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        ir_n       = ir;
        instr_rd_n = 1'b0;
        busy_n     = 1'b0;
        halted_n   = 1'b0;
        alu_a_n    = '0;
        alu_b_n    = '0;
        alu_op_n   = '0;

        case (state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_n = S_FETCH;
                    pc_n    = '0;
                end
            end
            S_FETCH:  state_n = S_DECODE;
            S_DECODE: begin
                state_n = S_EXEC;
                ir_n    = instr_data;
            end
            S_EXEC:   state_n = S_WB;
            S_WB: begin
                if (is_halt) begin
                    state_n = S_HALTED;
                end else begin
                    state_n = S_FETCH;
                    pc_n    = (is_branch && zero_q) ? ir[PC_W-1:0] : pc + PC_W'(1);
                end
            end
            default:  state_n = S_IDLE;
        endcase

        instr_rd_n = (state_n == S_FETCH);
        busy_n     = state_n inside {S_FETCH, S_DECODE, S_EXEC, S_WB};
        halted_n   = (state_n == S_HALTED);

        // Operands are presented during EXEC only for instructions that use the ALU
        if ((state_n == S_EXEC) && (ir_n[14:12] != OP_SPECIAL)) begin
            alu_a_n  = regs[ir_n[9:8]];
            alu_b_n  = regs[ir_n[7:6]];
            alu_op_n = ir_n[14:12];
        end
    end

endmodule

// File: tb/tb_alu_branch_sequencer.sv
// Bench for alu_branch_sequencer: program ROM and 4-bit ALU around the DUT, an
// instruction-level reference model feeding a scoreboard that is checked at each halt.
module tb_alu_branch_sequencer;
    localparam int unsigned PC_W   = 6;
    localparam int unsigned DATA_W = 4;
    localparam logic [15:0] HALT   = 16'h7000;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [15:0]     regs;
        logic [15:0]     cycles;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [PC_W-1:0]   instr_addr;
    logic              instr_rd;
    logic [15:0]       instr_data = '0;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic [2:0]        alu_op;
    logic              alu_zero;
    logic              busy, halted;
    logic [PC_W-1:0]   pc;
    logic [1:0]        dbg_sel;
    logic [DATA_W-1:0] dbg_data;

    logic [15:0]       rom [64];
    logic [3:0]        m_regs [4];
    exp_t              exp_q [$];
    int                n_tests = 0;
    int                n_fail  = 0;
    int                busy_cnt = 0;
    bit                prev_h = 1'b0;
    bit                prev_rst = 1'b0;

    alu_branch_sequencer #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .instr_addr(instr_addr), .instr_rd(instr_rd), .instr_data(instr_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy), .halted(halted), .pc(pc),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (instr_rd) instr_data <= rom[instr_addr];

    function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~(a & b);
            3'd6:    return (a < b) ? 4'd1 : 4'd0;
            default: return 4'd0;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_op);
    assign alu_zero   = (alu_result == 4'd0);

    function automatic logic [15:0] mk_alu(input logic [2:0] op, input logic [1:0] rd,
                                           input logic [1:0] rs, input logic [1:0] rt);
        return {1'b0, op, rd, rs, rt, 6'($urandom)};
    endfunction

    function automatic logic [15:0] mk_br(input logic [2:0] op, input logic [1:0] rs,
                                          input logic [1:0] rt, input logic [5:0] tgt);
        return {1'b1, op, 2'($urandom), rs, rt, tgt};
    endfunction

    function automatic logic [15:0] mk_ldi(input logic [1:0] rd, input logic [3:0] imm);
        return {1'b1, 3'b111, rd, 4'($urandom), 2'($urandom), imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = HALT;
    endtask

    // Instruction-set model: run the ROM from address 0 until HALT
    task automatic model_run(output logic [PC_W-1:0] fpc, output int ninstr);
        logic [PC_W-1:0] p;
        logic [15:0]     ins;
        p      = '0;
        fpc    = '0;
        ninstr = -1;
        for (int s = 1; s <= 1000; s++) begin
            ins = rom[p];
            if (ins[15:12] == 4'b0111) begin
                fpc    = p;
                ninstr = s;
                break;
            end
            if (ins[15] && ins[14:12] == 3'b111) begin
                m_regs[ins[11:10]] = ins[3:0];
                p = p + 6'd1;
            end else if (ins[15]) begin
                if (alu_f(m_regs[ins[9:8]], m_regs[ins[7:6]], ins[14:12]) == 4'd0) p = ins[5:0];
                else p = p + 6'd1;
            end else begin
                m_regs[ins[11:10]] = alu_f(m_regs[ins[9:8]], m_regs[ins[7:6]], ins[14:12]);
                p = p + 6'd1;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_prog(input bit poke);
        logic [PC_W-1:0] fpc;
        int              n;
        exp_t            e;
        bit              ok;
        model_run(fpc, n);
        e.pc     = fpc;
        e.regs   = {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
        e.cycles = 16'(4 * n);
        exp_q.push_back(e);
        pulse_start();
        if (poke) begin
            repeat (5) @(negedge clk);
            pulse_start();
        end
        ok = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (halted) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("halt reached", 32'(ok), 32'd1);
        @(negedge clk);
    endtask

    task automatic gen_random();
        int len;
        len = int'($urandom_range(3, 20));
        clear_rom();
        for (int i = 0; i < len; i++) begin
            case ($urandom_range(0, 2))
                0: rom[i] = mk_alu(3'($urandom_range(0, 6)), 2'($urandom), 2'($urandom), 2'($urandom));
                1: rom[i] = mk_ldi(2'($urandom), 4'($urandom));
                default: rom[i] = mk_br(3'($urandom_range(0, 6)), 2'($urandom), 2'($urandom),
                                        6'($urandom_range(i + 1, len)));
            endcase
        end
    endtask

    task automatic load_add_prog();
        clear_rom();
        rom[0] = mk_ldi(2'd1, 4'd3);
        rom[1] = mk_ldi(2'd2, 4'd4);
        rom[2] = mk_alu(3'b000, 2'd3, 2'd1, 2'd2);
    endtask

    // Monitor: regfile clear on each reset, scoreboard check on each rising halted
    initial begin : monitor
        exp_t e;
        dbg_sel = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (!prev_rst) begin
                    for (int r = 0; r < 4; r++) begin
                        dbg_sel = 2'(r);
                        #1;
                        check($sformatf("reset r%0d", r), 32'(dbg_data), 32'd0);
                    end
                end
                busy_cnt = 0;
                prev_h   = 1'b0;
                prev_rst = 1'b1;
            end else begin
                prev_rst = 1'b0;
                if (busy) busy_cnt++;
                if (halted && !prev_h) begin
                    check("scoreboard nonempty", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("halt pc", 32'(pc), 32'(e.pc));
                        check("busy cycles", 32'(busy_cnt), 32'(e.cycles));
                        for (int r = 0; r < 4; r++) begin
                            dbg_sel = 2'(r);
                            #1;
                            check($sformatf("reg r%0d", r), 32'(dbg_data), 32'(e.regs[r*4 +: 4]));
                        end
                    end
                    busy_cnt = 0;
                end
                prev_h = halted;
            end
        end
    end

    initial begin : stimulus
        bit ok;
        for (int r = 0; r < 4; r++) m_regs[r] = '0;
        clear_rom();
        repeat (3) @(negedge clk);
        check("reset outputs",
              32'({alu_a, alu_b, alu_op, instr_rd, busy, halted, pc, instr_addr}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // LDI r1,3; LDI r2,4; ADD r3; HALT
        load_add_prog();
        run_prog(1'b0);

        // Branch taken: r0 == r1 under op110
        clear_rom();
        rom[0] = mk_ldi(2'd0, 4'd2);
        rom[1] = mk_ldi(2'd1, 4'd2);
        rom[2] = mk_br(3'b110, 2'd0, 2'd1, 6'd5);
        run_prog(1'b0);

        // Branch not taken: r1 = 3
        rom[1] = mk_ldi(2'd1, 4'd3);
        run_prog(1'b0);

        // SUB to zero, then branch on the zero register
        clear_rom();
        rom[0] = mk_ldi(2'd0, 4'd5);
        rom[1] = mk_ldi(2'd1, 4'd5);
        rom[2] = mk_alu(3'b001, 2'd2, 2'd0, 2'd1);
        rom[3] = mk_br(3'b001, 2'd2, 2'd2, 6'd10);
        rom[4] = mk_ldi(2'd3, 4'd15);
        run_prog(1'b0);

        // Reset in the EXEC cycle of ADD, then rerun the same program
        load_add_prog();
        pulse_start();
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (busy && alu_a == 4'd3 && alu_b == 4'd4 && alu_op == 3'd0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reach ADD exec", 32'(ok), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("outputs under reset",
              32'({alu_a, alu_b, alu_op, instr_rd, busy, halted, pc, instr_addr}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 4; r++) m_regs[r] = '0;
        @(negedge clk);
        run_prog(1'b0);

        // Jump to 63, wrap to 0, with a start pulse while busy
        clear_rom();
        rom[0]  = mk_br(3'b000, 2'd0, 2'd0, 6'd63);
        rom[63] = mk_ldi(2'd0, 4'd1);
        run_prog(1'b1);

        for (int k = 0; k < 25; k++) begin
            gen_random();
            run_prog(1'b0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
